// File: rtl/flux_peak_detector_if.sv
// flux_peak_detector_if: sample stream into the peak detector and the
// per-transition event bus out of it. The slave modport is the detector;
// the master modport is the upstream filter / downstream timing side.
interface flux_peak_detector_if #(
  parameter int DATA_WIDTH     = 16,
  parameter int INTERVAL_WIDTH = 16
);
  logic signed [DATA_WIDTH-1:0] data_in;
  logic                         data_valid;
  logic                         flux_valid;
  logic                         flux_polarity;
  logic [DATA_WIDTH-2:0]        flux_peak;
  logic [INTERVAL_WIDTH-1:0]    flux_interval;

  modport master (
    output data_in, data_valid,
    input  flux_valid, flux_polarity, flux_peak, flux_interval
  );

  modport slave (
    input  data_in, data_valid,
    output flux_valid, flux_polarity, flux_peak, flux_interval
  );
endinterface

// File: rtl/flux_peak_detector.sv
// flux_peak_detector: finds the peak of each above-threshold excursion of
// the filtered flux signal (with hysteresis and post-event holdoff) and
// emits one event per transition: polarity, peak magnitude and the
// distance in accepted samples from the previous emitted peak.
// Optional macro FLUX_PEAK_STATS_EN adds stats_clr / peak_count /
// reject_count event statistics.
module flux_peak_detector #(
  parameter int DATA_WIDTH     = 16,
  parameter int INTERVAL_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DATA_WIDTH-2:0] threshold,
  input  logic [DATA_WIDTH-2:0] hysteresis,
  input  logic [7:0]            holdoff,
`ifdef FLUX_PEAK_STATS_EN
  input  logic                  stats_clr,
  output logic [15:0]           peak_count,
  output logic [15:0]           reject_count,
`endif
  flux_peak_detector_if.slave   bus
);

  localparam int MAG_W = DATA_WIDTH - 1;

  typedef enum logic [1:0] {SEARCH, TRACK, HOLDOFF} state_t;

  state_t                    r_state;
  logic [MAG_W-1:0]          r_peak;
  logic                      r_pol;
  logic [7:0]                r_hold;
  logic                      r_have_last;
  logic [INTERVAL_WIDTH-1:0] r_dist;
  logic [INTERVAL_WIDTH-1:0] r_age;
  logic [INTERVAL_WIDTH-1:0] r_cand_int;
  logic                      r_flux_valid;
  logic                      r_flux_polarity;
  logic [MAG_W-1:0]          r_flux_peak;
  logic [INTERVAL_WIDTH-1:0] r_flux_interval;

  logic                      w_accept;
  logic                      w_sign;
  logic [DATA_WIDTH-1:0]     w_din;
  logic [DATA_WIDTH-1:0]     w_neg;
  logic [MAG_W-1:0]          w_mag;
  logic [MAG_W-1:0]          w_floor;
  logic                      w_start;
  logic                      w_same;
  logic                      w_update;
  logic                      w_term;
  logic [INTERVAL_WIDTH-1:0] w_dist_cur;
  logic [INTERVAL_WIDTH-1:0] w_age_cur;

  // Magnitude, hysteresis floor and per-sample decision terms.
  always_comb begin
    w_accept = enable & bus.data_valid;
    w_din    = bus.data_in;
    w_sign   = w_din[DATA_WIDTH-1];
    w_neg    = (~w_din) + DATA_WIDTH'(1);
    w_mag    = w_din[MAG_W-1:0];
    if (w_sign) begin
      // Only the most negative input still has its top bit set after negation.
      w_mag = w_neg[DATA_WIDTH-1] ? '1 : w_neg[MAG_W-1:0];
    end
    w_floor    = (r_peak > hysteresis) ? (r_peak - hysteresis) : '0;
    w_start    = (w_mag >= threshold);
    w_same     = (r_pol == ~w_sign);
    w_update   = w_accept && (r_state == TRACK) && w_same && (w_mag > r_peak);
    w_term     = w_accept && (r_state == TRACK) && !w_update &&
                 (!w_same || (w_mag < w_floor));
    w_dist_cur = (r_dist == '1) ? r_dist : r_dist + INTERVAL_WIDTH'(1);
    w_age_cur  = (r_age  == '1) ? r_age  : r_age  + INTERVAL_WIDTH'(1);
  end

  // Detection FSM with registered event outputs.
  // Intervals are kept as saturating distances (last emitted peak -> current
  // sample, candidate peak -> current sample) rather than absolute indices,
  // so arbitrarily long gaps saturate without a wide sample counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= SEARCH;
      r_peak          <= '0;
      r_pol           <= 1'b0;
      r_hold          <= '0;
      r_have_last     <= 1'b0;
      r_dist          <= '0;
      r_age           <= '0;
      r_cand_int      <= '0;
      r_flux_valid    <= 1'b0;
      r_flux_polarity <= 1'b0;
      r_flux_peak     <= '0;
      r_flux_interval <= '0;
    end else begin
      r_flux_valid <= 1'b0;
      if (!enable) begin
        r_state     <= SEARCH;
        r_have_last <= 1'b0;
      end else if (bus.data_valid) begin
        r_dist <= w_dist_cur;
        r_age  <= w_age_cur;
        case (r_state)
          SEARCH: begin
            if (w_start) begin
              r_state    <= TRACK;
              r_peak     <= w_mag;
              r_pol      <= ~w_sign;
              r_cand_int <= w_dist_cur;
              r_age      <= '0;
            end
          end
          TRACK: begin
            if (w_update) begin
              r_peak     <= w_mag;
              r_cand_int <= w_dist_cur;
              r_age      <= '0;
            end else if (w_term) begin
              r_flux_valid    <= 1'b1;
              r_flux_polarity <= r_pol;
              r_flux_peak     <= r_peak;
              r_flux_interval <= r_have_last ? r_cand_int : '1;
              r_have_last     <= 1'b1;
              // The emitted peak becomes the new reference point.
              r_dist          <= w_age_cur;
              if (holdoff != '0) begin
                r_state <= HOLDOFF;
                r_hold  <= holdoff;
              end else if (w_start) begin
                r_state    <= TRACK;
                r_peak     <= w_mag;
                r_pol      <= ~w_sign;
                r_cand_int <= w_age_cur;
                r_age      <= '0;
              end else begin
                r_state <= SEARCH;
              end
            end
          end
          HOLDOFF: begin
            r_hold <= r_hold - 8'd1;
            if (r_hold <= 8'd1) begin
              r_state <= SEARCH;
            end
          end
          default: r_state <= SEARCH;
        endcase
      end
    end
  end

  assign bus.flux_valid    = r_flux_valid;
  assign bus.flux_polarity = r_flux_polarity;
  assign bus.flux_peak     = r_flux_peak;
  assign bus.flux_interval = r_flux_interval;

`ifdef FLUX_PEAK_STATS_EN
  logic [15:0] r_peak_count;
  logic [15:0] r_reject_count;
  logic        w_reject;

  assign w_reject = w_accept && (r_state == HOLDOFF) && w_start;

  // Saturating event / holdoff-reject counters; clear wins over increment.
  always_ff @(posedge clk) begin
    if (reset || stats_clr) begin
      r_peak_count   <= '0;
      r_reject_count <= '0;
    end else begin
      if (w_term && (r_peak_count != '1)) begin
        r_peak_count <= r_peak_count + 16'd1;
      end
      if (w_reject && (r_reject_count != '1)) begin
        r_reject_count <= r_reject_count + 16'd1;
      end
    end
  end

  assign peak_count   = r_peak_count;
  assign reject_count = r_reject_count;
`endif

endmodule

// File: tb/tb_flux_peak_detector.sv
// tb_flux_peak_detector: directed test-plan scenarios followed by random
// stimulus, every cycle compared against an index-based reference model.
module tb_flux_peak_detector;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [14:0] threshold;
  logic [14:0] hysteresis;
  logic [7:0]  holdoff;
`ifdef FLUX_PEAK_STATS_EN
  logic        stats_clr;
  logic [15:0] peak_count;
  logic [15:0] reject_count;
  int          m_pc;
  int          m_rc;
`endif

  flux_peak_detector_if #(.DATA_WIDTH(16), .INTERVAL_WIDTH(16)) bus_if ();

  flux_peak_detector #(.DATA_WIDTH(16), .INTERVAL_WIDTH(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .threshold    (threshold),
    .hysteresis   (hysteresis),
    .holdoff      (holdoff),
`ifdef FLUX_PEAK_STATS_EN
    .stats_clr    (stats_clr),
    .peak_count   (peak_count),
    .reject_count (reject_count),
`endif
    .bus          (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: absolute sample indices, plain integer arithmetic.
  int     m_mode;      // 0 search, 1 track, 2 holdoff
  longint m_idx;
  int     m_peak;
  bit     m_pol;
  longint m_pidx;
  longint m_last;
  bit     m_has_last;
  int     m_hold;
  bit     e_valid;
  bit     e_pol;
  int     e_peak;
  int     e_int;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_start(input int mag, input bit neg, input longint idx);
    m_mode = 1;
    m_peak = mag;
    m_pol  = !neg;
    m_pidx = idx;
  endtask

  task automatic model(input int d, input bit dv);
    int     mag;
    bit     neg;
    int     fl;
    bit     same;
    longint idx;
    int     thr;
    thr     = int'(threshold);
    e_valid = 0;
    if (reset) begin
      m_mode = 0; m_idx = 0; m_peak = 0; m_pol = 0; m_pidx = 0; m_last = 0;
      m_has_last = 0; m_hold = 0;
      e_pol = 0; e_peak = 0; e_int = 0;
`ifdef FLUX_PEAK_STATS_EN
      m_pc = 0; m_rc = 0;
`endif
      return;
    end
`ifdef FLUX_PEAK_STATS_EN
    if (stats_clr) begin
      m_pc = 0; m_rc = 0;
    end
`endif
    if (!enable) begin
      m_mode = 0;
      m_has_last = 0;
      return;
    end
    if (!dv) return;
    neg = (d < 0);
    mag = neg ? ((d == -32768) ? 32767 : -d) : d;
    idx = m_idx;
    m_idx++;
    case (m_mode)
      0: if (mag >= thr) model_start(mag, neg, idx);
      1: begin
        same = (m_pol == !neg);
        fl   = m_peak - int'(hysteresis);
        if (fl < 0) fl = 0;
        if (same && mag > m_peak) begin
          m_peak = mag;
          m_pidx = idx;
        end else if (!same || mag < fl) begin
          e_valid = 1;
          e_pol   = m_pol;
          e_peak  = m_peak;
          e_int   = m_has_last ? ((m_pidx - m_last > 65535) ? 65535 : int'(m_pidx - m_last)) : 65535;
          m_last  = m_pidx;
          m_has_last = 1;
`ifdef FLUX_PEAK_STATS_EN
          if (!stats_clr && m_pc < 65535) m_pc++;
`endif
          if (holdoff != 0) begin
            m_mode = 2;
            m_hold = int'(holdoff);
          end else if (mag >= thr) begin
            model_start(mag, neg, idx);
          end else begin
            m_mode = 0;
          end
        end
      end
      default: begin
`ifdef FLUX_PEAK_STATS_EN
        if (mag >= thr && !stats_clr && m_rc < 65535) m_rc++;
`endif
        m_hold--;
        if (m_hold == 0) m_mode = 0;
      end
    endcase
  endtask

  task automatic check_all();
    chk("flux_valid",    32'(bus_if.flux_valid),    32'(e_valid));
    chk("flux_polarity", 32'(bus_if.flux_polarity), 32'(e_pol));
    chk("flux_peak",     32'(bus_if.flux_peak),     32'(e_peak));
    chk("flux_interval", 32'(bus_if.flux_interval), 32'(e_int));
`ifdef FLUX_PEAK_STATS_EN
    chk("peak_count",    32'(peak_count),           32'(m_pc));
    chk("reject_count",  32'(reject_count),         32'(m_rc));
`endif
  endtask

  task automatic step(input int d, input bit dv);
    bus_if.data_in    = 16'(d);
    bus_if.data_valid = dv;
    model(d, dv);
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    reset = 1; enable = 1; threshold = 15'd1000; hysteresis = 15'd200; holdoff = 8'd4;
    bus_if.data_in = '0; bus_if.data_valid = 0;
`ifdef FLUX_PEAK_STATS_EN
    stats_clr = 0;
`endif
    step(0, 1);
    step(0, 1);
    reset = 0;

    // Basic positive peak.
    step(0, 1); step(500, 1); step(1200, 1); step(1800, 1); step(1500, 1);
    chk("basic_valid", 32'(bus_if.flux_valid), 32'd1);
    chk("basic_peak",  32'(bus_if.flux_peak), 32'd1800);
    chk("basic_pol",   32'(bus_if.flux_polarity), 32'd1);
    chk("basic_int",   32'(bus_if.flux_interval), 32'd65535);
    step(0, 1);
    chk("basic_strobe_1cyc", 32'(bus_if.flux_valid), 32'd0);

    // Negative peak 10 samples after the 1800 sample (one gap cycle included).
    step(0, 1); step(0, 0); step(0, 1); step(0, 1);
    for (int i = 0; i < 4; i++) step(0, 1);
    step(-2000, 1); step(-1500, 1);
    chk("neg_pol",  32'(bus_if.flux_polarity), 32'd0);
    chk("neg_peak", 32'(bus_if.flux_peak), 32'd2000);
    chk("neg_int",  32'(bus_if.flux_interval), 32'd10);
    holdoff = 8'd0;
    for (int i = 0; i < 4; i++) step(0, 1);

    // Back-to-back polarity flip with no holdoff.
    step(1500, 1); step(-1500, 1);
    chk("b2b_first_pol",  32'(bus_if.flux_polarity), 32'd1);
    chk("b2b_first_peak", 32'(bus_if.flux_peak), 32'd1500);
    step(0, 1);
    chk("b2b_second_valid", 32'(bus_if.flux_valid), 32'd1);
    chk("b2b_second_pol",   32'(bus_if.flux_polarity), 32'd0);
    chk("b2b_second_int",   32'(bus_if.flux_interval), 32'd1);

    // Holdoff rejection.
    holdoff = 8'd8;
    step(1500, 1); step(0, 1);
    step(0, 1); step(0, 1); step(1500, 1);
    chk("holdoff_no_event", 32'(bus_if.flux_valid), 32'd0);
`ifdef FLUX_PEAK_STATS_EN
    chk("holdoff_reject", 32'(reject_count), 32'd1);
`endif
    for (int i = 0; i < 5; i++) step(0, 1);

    // Saturation of magnitude and interval.
    holdoff = 8'd0;
    step(-32768, 1); step(0, 1);
    chk("sat_peak", 32'(bus_if.flux_peak), 32'd32767);
    for (int i = 0; i < 66000; i++) step(0, 1);
    step(1500, 1); step(0, 1);
    chk("sat_int", 32'(bus_if.flux_interval), 32'd65535);

    // Reset mid-TRACK.
    step(1500, 1);
    reset = 1; step(0, 1); reset = 0;
    chk("rst_valid", 32'(bus_if.flux_valid), 32'd0);
    chk("rst_peak",  32'(bus_if.flux_peak), 32'd0);
    chk("rst_int",   32'(bus_if.flux_interval), 32'd0);
    step(1500, 1); step(0, 1);
    chk("rst_next_int", 32'(bus_if.flux_interval), 32'd65535);

    // Enable low mid-TRACK.
    step(1500, 1);
    enable = 0; step(0, 1); enable = 1;
    chk("en_no_event", 32'(bus_if.flux_valid), 32'd0);
    step(0, 1);
    chk("en_discard", 32'(bus_if.flux_valid), 32'd0);
    step(2500, 1); step(0, 1);
    chk("en_next_peak", 32'(bus_if.flux_peak), 32'd2500);
    chk("en_next_int",  32'(bus_if.flux_interval), 32'd65535);

`ifdef FLUX_PEAK_STATS_EN
    stats_clr = 1; step(0, 1); stats_clr = 0;
    chk("stats_clr", 32'(peak_count), 32'd0);
`endif

    // Random stimulus against the model.
    for (int i = 0; i < 6000; i++) begin
      int d;
      if (i % 500 == 0) begin
        threshold  = 15'($urandom_range(300, 2000));
        hysteresis = 15'($urandom_range(0, 600));
        holdoff    = 8'($urandom_range(0, 6));
      end
      enable = ($urandom_range(0, 99) != 0);
`ifdef FLUX_PEAK_STATS_EN
      stats_clr = ($urandom_range(0, 199) == 0);
`endif
      case ($urandom_range(0, 49))
        0:       d = -32768;
        1:       d = 32767;
        default: d = int'($urandom_range(0, 6000)) - 3000;
      endcase
      step(d, $urandom_range(0, 9) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/flux_peak_detector.md
# flux_peak_detector

Flux-transition peak detector directly downstream of `fir_flux_filter`. Consumes the filter's signed 16-bit output stream, finds the peak of each above-threshold excursion with hysteresis and a post-peak holdoff, and emits one event per flux transition: polarity, peak magnitude, and the interval since the previous transition in sample periods. Its events feed the data-separator/timing stages.

## Interface
Parameters:
- `DATA_WIDTH`, 16: input sample width, signed two's complement. Matches the filter `OUTPUT_WIDTH`.
- `INTERVAL_WIDTH`, 16: interval output width. Saturating.

Ports:
- `clk`  in  1  single clock for all logic.
- `reset`  in  1  synchronous, active-high; resets all state and outputs on the next `clk` edge.
- `enable`  in  1  0 forces SEARCH, ignores input, and suppresses events.
- `data_in`  in  16  filtered sample, signed.
- `data_valid`  in  1  qualifies `data_in`; may be high every cycle.
- `threshold`  in  15  minimum magnitude that starts a peak.
- `hysteresis`  in  15  drop below the running peak that ends it.
- `holdoff`  in  8  valid samples ignored after each event.
- `flux_valid`  out  1  one-cycle event strobe.
- `flux_polarity`  out  1  1 = positive peak, 0 = negative.
- `flux_peak`  out  15  peak magnitude.
- `flux_interval`  out  16  samples from previous peak sample to this one.

## Operation
- Magnitude: `mag = |data_in|`. Input -32768 saturates to 32767. Sign is `data_in[15]`.
- Sample counter: counts accepted samples (`enable & data_valid`).
- States:
  - SEARCH: on an accepted sample with `mag >= threshold`, go to TRACK. Latch `peak=mag`, `pol=~sign`, and the peak index.
  - TRACK: on each accepted sample:
    - Same sign and `mag > peak`: update `peak` and index. Ties keep the earlier sample.
    - Sign flips, or `mag < peak - hysteresis` (subtraction floors at 0): terminate and emit the event.
    - Otherwise stay in TRACK.
  - After termination:
    - If `holdoff != 0`, go to HOLDOFF with a counter loaded to `holdoff`.
    - If `holdoff == 0`, the terminating sample is re-evaluated as in SEARCH. It may start a new TRACK of opposite polarity in the same cycle.
  - HOLDOFF: each accepted sample decrements the counter. Such samples never start a peak. At 0, go to SEARCH.
- Interval: index difference between consecutive emitted peak samples, saturating at 65535.
  - First event after reset, or after `enable` deasserts, reports 65535.
- `enable` low: state becomes SEARCH, any in-progress TRACK is discarded with no event, and the interval history is cleared.

## Timing
- Reset values: `flux_valid=0`, `flux_polarity=0`, `flux_peak=0`, `flux_interval=0`, state SEARCH, all counters 0.
- Latency: `flux_valid` is high in the cycle after the edge that accepts the terminating sample. It stays high for exactly 1 cycle.
- `flux_polarity`, `flux_peak` and `flux_interval` update together with `flux_valid` and hold until the next event.
- Full throughput: 1 sample per cycle, no backpressure. Gaps in `data_valid` do not advance any counter.
- Reset during TRACK or HOLDOFF: no event is emitted; the next event reports interval 65535.
- `threshold`, `hysteresis` and `holdoff` are sampled per accepted sample. Changes take effect on the next accepted sample.

## Configuration
- `FLUX_PEAK_STATS_EN` defined adds these ports:
  - `stats_clr`  in  1
  - `peak_count`  out  16: events emitted.
  - `reject_count`  out  16: HOLDOFF samples with `mag >= threshold`.
- Both counters saturate at 65535. They clear on `reset` or on `stats_clr`; `stats_clr` wins over a simultaneous increment.
- Undefined: these ports and their logic are absent. Detection behaviour is identical.

## Test plan
- Basic positive peak: `threshold=1000`, `hysteresis=200`, `holdoff=4`; samples 0, 500, 1200, 1800, 1500. Required: one `flux_valid` 1 cycle after 1500 is accepted, with `flux_peak=1800`, `flux_polarity=1`, `flux_interval=65535`.
- Interval: a negative excursion peaking at -2000, whose peak sample is 10 samples after the 1800 sample. Required: `flux_polarity=0`, `flux_peak=2000`, `flux_interval=10`.
- Back-to-back flip: `holdoff=0`; samples +1500, -1500, 0. Required: two events on consecutive accepted samples, positive peak 1500 then negative peak 1500 with `flux_interval=1`.
- Holdoff rejection: `holdoff=8`; an above-threshold sample 3 samples after an event. Required: no `flux_valid`; `reject_count=1` when the macro is defined.
- Saturation: a -32768 peak gives `flux_peak=32767`. More than 65535 samples between peaks gives `flux_interval=65535`.
- Reset/enable mid-TRACK: assert `reset` 1 cycle during TRACK. Required: no event, all outputs 0. Repeat with `enable` low: no event, and the next event reports interval 65535.
